redun_mont_sq_seq: RTL and testbench

- Sequencer that time-shares one multi_mode_multiplier instance to run repeated Montgomery squarings on a redundant-form operand.
- Each squaring has three multiplier passes:
  - SQ: T = x*x, full product.
  - LO: m = T_lo * MPRIME, low half only.
  - HI: T_hi + m*MODULUS, upper half.
- The sequencer drives the multiplier controls and operands, waits a fixed pipeline latency per pass, captures results and loops a programmable number of times.
- It sits between the VDF top-level input/output registers and the multiplier.

---
 rtl/common_pkg.sv | 7 +
 rtl/redun_mont_pkg.sv | 37 +++
 rtl/redun_mont_wait_cnt.sv | 27 ++
 rtl/redun_mont_sq_seq.sv | 185 ++++++++++++++++++
 tb/tb_redun_mont_sq_seq.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Project-wide defaults shared by the VDF datapath blocks.
package common_pkg;

  localparam int unsigned DEF_MUL_LAT  = 4;
  localparam int unsigned DEF_CNT_BITS = 32;

endpackage

// File: rtl/redun_mont_pkg.sv
// Redundant-form operand types, Montgomery constants and multiplier mode codes.
package redun_mont_pkg;

  localparam int unsigned NUM_WRDS  = 16;
  localparam int unsigned WRD_BITS  = 16;
  localparam int unsigned WRD_W     = WRD_BITS + 1;
  localparam int unsigned BASE_BITS = NUM_WRDS * WRD_BITS;

  typedef logic [NUM_WRDS-1:0][WRD_BITS:0]   redun0_t;
  typedef logic [2*NUM_WRDS-1:0][WRD_BITS:0] redun1_t;

  localparam logic [2:0] CTL_LO     = 3'b001;
  localparam logic [2:0] CTL_FULL   = 3'b010;
  localparam logic [2:0] CTL_HI_ADD = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQ,
    ST_LO,
    ST_HI,
    ST_DONE
  } seq_state_t;

  // Split a plain binary value into words with the redundant bit cleared.
  function automatic redun0_t to_redun0(input logic [BASE_BITS-1:0] v);
    redun0_t r;
    for (int i = 0; i < NUM_WRDS; i++) begin
      r[i] = {1'b0, v[i*WRD_BITS +: WRD_BITS]};
    end
    return r;
  endfunction

  // MODULUS = 2^254 + 1, MPRIME = -MODULUS^-1 mod 2^256 = 2^254 - 1.
  localparam redun0_t MODULUS = to_redun0((BASE_BITS'(1) << (BASE_BITS - 2)) | BASE_BITS'(1));
  localparam redun0_t MPRIME  = to_redun0((BASE_BITS'(1) << (BASE_BITS - 2)) - BASE_BITS'(1));

endpackage

// File: rtl/redun_mont_wait_cnt.sv
// Loadable down-counter; o_last_c flags the final cycle of a multiplier pass.
module redun_mont_wait_cnt #(
  parameter int unsigned LOAD_VAL = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_last_c
);

  localparam int unsigned CW = $clog2(LOAD_VAL + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= CW'(LOAD_VAL);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign o_last_c = (cnt_q == '0);

endmodule

// File: rtl/redun_mont_sq_seq.sv
// Repeated Montgomery squaring sequencer driving one shared multiplier.
// Optional busy-cycle counter enabled by REDUN_MONT_SQ_SEQ_PERF_EN.
module redun_mont_sq_seq
  import common_pkg::*;
  import redun_mont_pkg::*;
#(
  parameter int unsigned MUL_LAT  = DEF_MUL_LAT,
  parameter int unsigned CNT_BITS = DEF_CNT_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [CNT_BITS-1:0] i_num_sq,
  input  redun0_t             i_dat,
  output logic                o_busy,
  output logic                o_val,
  output redun0_t             o_dat,
  output logic [2:0]          o_mul_ctl,
  output redun0_t             o_mul_a,
  output redun0_t             o_mul_b,
  output redun0_t             o_mul_add,
`ifdef REDUN_MONT_SQ_SEQ_PERF_EN
  output logic [CNT_BITS-1:0] o_perf_cycles,
`endif
  input  redun1_t             i_mul_dat
);

  seq_state_t          state_q, state_d;
  redun0_t             x_q, x_d;
  redun0_t             t_lo_q, t_lo_d;
  redun0_t             t_hi_q, t_hi_d;
  redun0_t             m_q, m_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                busy_d, val_d;
  redun0_t             dat_d, a_d, b_d, add_d;
  logic [2:0]          ctl_d;
  logic                wait_load, wait_last;
  logic                t_lo_nz;

  redun_mont_wait_cnt #(
    .LOAD_VAL(MUL_LAT)
  ) u_wait_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (wait_load),
    .o_last_c(wait_last)
  );

  // Carry out of the discarded low half: T_lo + (m*N mod R) is R unless T_lo is zero.
  assign t_lo_nz = |t_lo_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      t_lo_q    <= '0;
      t_hi_q    <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      o_busy    <= 1'b0;
      o_val     <= 1'b0;
      o_dat     <= '0;
      o_mul_ctl <= CTL_FULL;
      o_mul_a   <= '0;
      o_mul_b   <= '0;
      o_mul_add <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      t_lo_q    <= t_lo_d;
      t_hi_q    <= t_hi_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      o_busy    <= busy_d;
      o_val     <= val_d;
      o_dat     <= dat_d;
      o_mul_ctl <= ctl_d;
      o_mul_a   <= a_d;
      o_mul_b   <= b_d;
      o_mul_add <= add_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    t_lo_d    = t_lo_q;
    t_hi_d    = t_hi_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    busy_d    = o_busy;
    val_d     = 1'b0;
    dat_d     = o_dat;
    ctl_d     = o_mul_ctl;
    a_d       = o_mul_a;
    b_d       = o_mul_b;
    add_d     = o_mul_add;
    wait_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          x_d    = i_dat;
          cnt_d  = i_num_sq;
          busy_d = 1'b1;
          if (i_num_sq == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_SQ;
            wait_load = 1'b1;
          end
        end
      end
      ST_SQ: begin
        ctl_d = CTL_FULL;
        a_d   = x_q;
        b_d   = x_q;
        add_d = '0;
        if (wait_last) begin
          t_lo_d    = i_mul_dat[NUM_WRDS-1:0];
          t_hi_d    = i_mul_dat[2*NUM_WRDS-1:NUM_WRDS];
          state_d   = ST_LO;
          wait_load = 1'b1;
        end
      end
      ST_LO: begin
        ctl_d = CTL_LO;
        a_d   = t_lo_q;
        b_d   = MPRIME;
        add_d = '0;
        if (wait_last) begin
          for (int i = 0; i < NUM_WRDS; i++) begin
            m_d[i] = {1'b0, i_mul_dat[i][WRD_BITS-1:0]};
          end
          state_d   = ST_HI;
          wait_load = 1'b1;
        end
      end
      ST_HI: begin
        ctl_d = CTL_HI_ADD;
        a_d   = m_q;
        b_d   = MODULUS;
        add_d = t_hi_q;
        if (wait_last) begin
          x_d    = i_mul_dat[2*NUM_WRDS-1:NUM_WRDS];
          x_d[0] = i_mul_dat[NUM_WRDS] + WRD_W'(t_lo_nz);
          cnt_d  = cnt_q - CNT_BITS'(1);
          if (cnt_q == CNT_BITS'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_SQ;
            wait_load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        dat_d   = x_q;
        val_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef REDUN_MONT_SQ_SEQ_PERF_EN
  logic start_acc_c;

  assign start_acc_c = (state_q == ST_IDLE) && i_start;

  // Busy-cycle count, cleared on acceptance and saturating at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_cycles <= '0;
    end else if (start_acc_c) begin
      o_perf_cycles <= '0;
    end else if (o_busy && (o_perf_cycles != '1)) begin
      o_perf_cycles <= o_perf_cycles + CNT_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_redun_mont_sq_seq.sv
// Directed bench for redun_mont_sq_seq with a behavioural 4-cycle multiplier.
module tb_redun_mont_sq_seq;
  import redun_mont_pkg::*;

  localparam logic [639:0] N_VAL  = (640'd1 << 254) + 640'd1;
  localparam logic [639:0] EXP_1  = 640'd1 << 254;
  localparam logic [639:0] EXP_10 = 640'd1 << 24;

  logic          clk;
  logic          rst;
  logic          start;
  logic [31:0]   num_sq;
  redun0_t       dat_in;
  logic          busy;
  logic          val;
  redun0_t       dat_out;
  logic [2:0]    mul_ctl;
  redun0_t       mul_a, mul_b, mul_add;
  redun1_t       mul_dat;
`ifdef REDUN_MONT_SQ_SEQ_PERF_EN
  logic [31:0]   perf;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  redun_mont_sq_seq dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_num_sq (num_sq),
    .i_dat    (dat_in),
    .o_busy   (busy),
    .o_val    (val),
    .o_dat    (dat_out),
    .o_mul_ctl(mul_ctl),
    .o_mul_a  (mul_a),
    .o_mul_b  (mul_b),
    .o_mul_add(mul_add),
`ifdef REDUN_MONT_SQ_SEQ_PERF_EN
    .o_perf_cycles(perf),
`endif
    .i_mul_dat(mul_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [639:0] val0(input redun0_t r);
    logic [639:0] v;
    v = '0;
    for (int i = 0; i < NUM_WRDS; i++) v = v + (640'(r[i]) << (16 * i));
    return v;
  endfunction

  function automatic redun1_t norm1(input logic [639:0] v);
    redun1_t r;
    for (int i = 0; i < 31; i++) r[i] = {1'b0, v[16*i +: 16]};
    r[31] = v[496 +: 17];
    return r;
  endfunction

  function automatic redun1_t mul_model(input logic [2:0] ctl, input redun0_t a, input redun0_t b,
                                        input redun0_t add);
    logic [639:0] p;
    p = val0(a) * val0(b);
    case (ctl)
      3'b010:  p = p;
      3'b001:  p = p & ((640'd1 << 256) - 640'd1);
      3'b100:  p = p + (val0(add) << 256);
      default: p = '0;
    endcase
    return norm1(p);
  endfunction

  function automatic redun0_t mk_x(input int unsigned wrd, input int unsigned v);
    redun0_t r;
    r = '0;
    r[wrd] = 17'(v);
    return r;
  endfunction

  // Multiplier stand-in: result visible MUL_LAT cycles after operands change.
  redun1_t pipe [3];
  initial for (int i = 0; i < 3; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= mul_model(mul_ctl, mul_a, mul_b, mul_add);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign mul_dat = pipe[2];

  // Leaves the caller at the falling edge of the first cycle after acceptance.
  task automatic do_start(input logic [31:0] n, input redun0_t x);
    @(negedge clk);
    start  = 1'b1;
    num_sq = n;
    dat_in = x;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_val(input int limit, output int lat);
    int k;
    k = 1;
    while (val !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    lat = (val === 1'b1) ? k : -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests_run++; if (val !== 1'b0) begin tests_failed++; $display("FAIL reset_val got %0b want 0", val); end
    tests_run++; if (dat_out !== '0) begin tests_failed++; $display("FAIL reset_dat got %0h want 0", dat_out); end
    tests_run++; if (mul_ctl !== 3'b010) begin tests_failed++; $display("FAIL reset_ctl got %b want 010", mul_ctl); end
    tests_run++; if (mul_a !== '0) begin tests_failed++; $display("FAIL reset_mul_a got %0h want 0", mul_a); end
    tests_run++; if (mul_add !== '0) begin tests_failed++; $display("FAIL reset_mul_add got %0h want 0", mul_add); end
  endtask

  task automatic test_zero_iter;
    int lat;
    do_start(32'd0, mk_x(0, 5));
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL zero_busy got %0b want 1", busy); end
    wait_val(10, lat);
    tests_run++; if (lat != 2) begin tests_failed++; $display("FAIL zero_lat got %0d want 2", lat); end
    tests_run++; if (dat_out !== mk_x(0, 5)) begin tests_failed++; $display("FAIL zero_dat got %0h want 5", dat_out); end
    tests_run++; if (mul_ctl !== 3'b010) begin tests_failed++; $display("FAIL zero_ctl got %b want 010", mul_ctl); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy_end got %0b want 0", busy); end
    @(negedge clk);
    tests_run++; if (val !== 1'b0) begin tests_failed++; $display("FAIL zero_pulse got %0b want 0", val); end
  endtask

  task automatic test_one_sq;
    logic [2:0]   exp_ctl;
    logic [639:0] res;
    do_start(32'd1, mk_x(0, 2));
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) @(negedge clk);
      exp_ctl = (k <= 6) ? 3'b010 : ((k <= 11) ? 3'b001 : 3'b100);
      tests_run++;
      if (mul_ctl !== exp_ctl) begin
        tests_failed++; $display("FAIL one_ctl cycle %0d got %b want %b", k, mul_ctl, exp_ctl);
      end
      tests_run++;
      if (val !== (k == 17)) begin
        tests_failed++; $display("FAIL one_val cycle %0d got %0b want %0b", k, val, (k == 17));
      end
    end
    res = val0(dat_out) % N_VAL;
    tests_run++; if (res !== EXP_1) begin tests_failed++; $display("FAIL one_res got %0h want %0h", res, EXP_1); end
`ifdef REDUN_MONT_SQ_SEQ_PERF_EN
    tests_run++; if (perf !== 32'd16) begin tests_failed++; $display("FAIL one_perf got %0d want 16", perf); end
`endif
    repeat (3) @(negedge clk);
    res = val0(dat_out) % N_VAL;
    tests_run++; if (res !== EXP_1) begin tests_failed++; $display("FAIL one_hold got %0h want %0h", res, EXP_1); end
  endtask

  task automatic test_ten_sq;
    int           lat;
    logic [639:0] res;
    do_start(32'd10, mk_x(6, 16));
    wait_val(400, lat);
    tests_run++; if (lat != 152) begin tests_failed++; $display("FAIL ten_lat got %0d want 152", lat); end
    res = val0(dat_out) % N_VAL;
    tests_run++; if (res !== EXP_10) begin tests_failed++; $display("FAIL ten_res got %0h want %0h", res, EXP_10); end
  endtask

  task automatic test_start_busy;
    int           nval, lat;
    logic [639:0] res;
    nval = 0;
    lat  = -1;
    do_start(32'd1, mk_x(0, 2));
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 8) begin start = 1'b1; num_sq = 32'd0; dat_in = mk_x(0, 3); end
      if (k == 9) start = 1'b0;
      if (val === 1'b1) begin
        nval++;
        if (lat < 0) lat = k;
      end
    end
    tests_run++; if (nval != 1) begin tests_failed++; $display("FAIL busy_nval got %0d want 1", nval); end
    tests_run++; if (lat != 17) begin tests_failed++; $display("FAIL busy_lat got %0d want 17", lat); end
    res = val0(dat_out) % N_VAL;
    tests_run++; if (res !== EXP_1) begin tests_failed++; $display("FAIL busy_res got %0h want %0h", res, EXP_1); end
  endtask

  task automatic test_back_to_back;
    do_start(32'd0, mk_x(0, 5));
    start  = 1'b1;
    dat_in = mk_x(0, 7);
    @(negedge clk);
    tests_run++; if (val !== 1'b1) begin tests_failed++; $display("FAIL b2b_val1 got %0b want 1", val); end
    tests_run++; if (dat_out !== mk_x(0, 5)) begin tests_failed++; $display("FAIL b2b_dat1 got %0h want 5", dat_out); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_start got %0b want 0", busy); end
    dat_in = mk_x(0, 9);
    @(negedge clk);
    start = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept got %0b want 1", busy); end
    @(negedge clk);
    tests_run++; if (val !== 1'b1) begin tests_failed++; $display("FAIL b2b_val2 got %0b want 1", val); end
    tests_run++; if (dat_out !== mk_x(0, 9)) begin tests_failed++; $display("FAIL b2b_dat2 got %0h want 9", dat_out); end
  endtask

  task automatic test_reset_mid_hi;
    int           nval, lat;
    logic [639:0] res;
    nval = 0;
    do_start(32'hFFFF_FFFF, mk_x(0, 2));
    for (int k = 1; k <= 102; k++) begin
      if (k > 1) @(negedge clk);
      if (val === 1'b1) nval++;
    end
    tests_run++; if (nval != 0) begin tests_failed++; $display("FAIL ones_val got %0d want 0", nval); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ones_busy got %0b want 1", busy); end
    tests_run++; if (mul_ctl !== 3'b100) begin tests_failed++; $display("FAIL ones_in_hi got %b want 100", mul_ctl); end
    rst = 1'b1;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy got %0b want 0", busy); end
    tests_run++; if (val !== 1'b0) begin tests_failed++; $display("FAIL mid_val got %0b want 0", val); end
    tests_run++; if (dat_out !== '0) begin tests_failed++; $display("FAIL mid_dat got %0h want 0", dat_out); end
    tests_run++; if (mul_ctl !== 3'b010) begin tests_failed++; $display("FAIL mid_ctl got %b want 010", mul_ctl); end
    tests_run++; if (mul_a !== '0) begin tests_failed++; $display("FAIL mid_mul_a got %0h want 0", mul_a); end
    tests_run++; if (mul_add !== '0) begin tests_failed++; $display("FAIL mid_mul_add got %0h want 0", mul_add); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_start(32'd1, mk_x(0, 2));
    wait_val(40, lat);
    tests_run++; if (lat != 17) begin tests_failed++; $display("FAIL post_lat got %0d want 17", lat); end
    res = val0(dat_out) % N_VAL;
    tests_run++; if (res !== EXP_1) begin tests_failed++; $display("FAIL post_res got %0h want %0h", res, EXP_1); end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    num_sq = '0;
    dat_in = '0;
    test_reset;
    test_zero_iter;
    test_one_sq;
    test_ten_sq;
    test_start_busy;
    test_back_to_back;
    test_reset_mid_hi;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
